// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The IR stage imports the same len encodings.
package fetch_pkg;

  typedef enum logic [2:0] {
    FETCH_OP = 3'd0,
    FETCH_D1 = 3'd1,
    FETCH_D2 = 3'd2,
    ISSUE    = 3'd3,
    HALT     = 3'd4
  } state_t;

  localparam logic [1:0] LEN_1B = 2'd0;
  localparam logic [1:0] LEN_2B = 2'd1;
  localparam logic [1:0] LEN_3B = 2'd2;

  // Opcode bit field that carries the instruction length
  localparam int OP_LEN_MSB = 7;
  localparam int OP_LEN_LSB = 6;

  // Program counter advance; wraps modulo 2^16 with no flag
  function automatic logic [15:0] pc_inc(input logic [15:0] a);
    return a + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Byte-wide program memory read port between fetch (master) and memory (slave).
interface fetch_if;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport master (output mem_addr, output mem_req, input mem_ack, input mem_rdata);
  modport slave  (input mem_addr, input mem_req, output mem_ack, output mem_rdata);
endinterface

// File: rtl/fetch_len_decode.sv
// Opcode length decode; shared with the disassembler so both read one table.
module fetch_len_decode
  import fetch_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] len,
  output logic       illegal
);

  // Map the length field to a len code and flag the reserved encoding
  always_comb begin
    len     = LEN_1B;
    illegal = 1'b0;
    case (opcode[OP_LEN_MSB:OP_LEN_LSB])
      2'b00: len = LEN_1B;
      2'b01: len = LEN_2B;
      2'b10: len = LEN_3B;
      2'b11: begin
        len     = LEN_1B;
        illegal = 1'b1;
      end
      default: begin
        len     = LEN_1B;
        illegal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: walks pc through program memory, packs opcode+operands.
// Optional illegal-opcode trap (HALT state, fault output) under FETCH_ILLEGAL_TRAP_EN.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_VEC = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_if.master       mem,
  input  logic          hold,
  input  logic          pc_load,
  input  logic [15:0]   pc_target,
  output logic [23:0]   raw,
  output logic [1:0]    len,
  output logic          ir_we,
  output logic [15:0]   pc,
  output logic          fault
);

  state_t      state_r, state_n;
  logic [15:0] pc_r, pc_n;
  logic [23:0] raw_r, raw_n;
  logic [1:0]  len_r, len_n;
  logic        run_r;
  logic        req_s;
  logic        ack_s;
  logic [1:0]  dec_len_s;
  logic        illegal_s;

  fetch_len_decode u_len_decode (
    .opcode  (mem.mem_rdata),
    .len     (dec_len_s),
    .illegal (illegal_s)
  );

`ifndef FETCH_ILLEGAL_TRAP_EN
  logic unused_illegal_s;
  assign unused_illegal_s = illegal_s;
`endif

  // run_r keeps the request low through the first cycle out of reset
  assign req_s = run_r && ((state_r == FETCH_OP) || (state_r == FETCH_D1) ||
                           (state_r == FETCH_D2));
  assign ack_s = req_s && mem.mem_ack;

  assign mem.mem_req  = req_s;
  assign mem.mem_addr = pc_r;
  assign pc           = pc_r;
  assign raw          = raw_r;
  assign len          = len_r;
  assign ir_we        = (state_r == ISSUE) && !hold && !pc_load;

`ifdef FETCH_ILLEGAL_TRAP_EN
  assign fault = (state_r == HALT);
`else
  assign fault = 1'b0;
`endif

  // Next-state, pc and instruction assembly; redirect beats ack and issue
  always_comb begin
    state_n = state_r;
    pc_n    = pc_r;
    raw_n   = raw_r;
    len_n   = len_r;
    if (pc_load) begin
      state_n = FETCH_OP;
      pc_n    = pc_target;
    end else begin
      case (state_r)
        FETCH_OP: begin
          if (ack_s) begin
            raw_n = {mem.mem_rdata, 16'h0000};
            len_n = dec_len_s;
            pc_n  = pc_inc(pc_r);
`ifdef FETCH_ILLEGAL_TRAP_EN
            if (illegal_s) begin
              state_n = HALT;
            end else begin
              state_n = (dec_len_s == LEN_1B) ? ISSUE : FETCH_D1;
            end
`else
            state_n = (dec_len_s == LEN_1B) ? ISSUE : FETCH_D1;
`endif
          end else begin
            state_n = FETCH_OP;
          end
        end
        FETCH_D1: begin
          if (ack_s) begin
            raw_n[15:8] = mem.mem_rdata;
            pc_n        = pc_inc(pc_r);
            state_n     = (len_r == LEN_3B) ? FETCH_D2 : ISSUE;
          end else begin
            state_n = FETCH_D1;
          end
        end
        FETCH_D2: begin
          if (ack_s) begin
            raw_n[7:0] = mem.mem_rdata;
            pc_n       = pc_inc(pc_r);
            state_n    = ISSUE;
          end else begin
            state_n = FETCH_D2;
          end
        end
        ISSUE: begin
          if (!hold) begin
            state_n = FETCH_OP;
          end else begin
            state_n = ISSUE;
          end
        end
`ifdef FETCH_ILLEGAL_TRAP_EN
        HALT: state_n = HALT;
`endif
        default: state_n = FETCH_OP;
      endcase
    end
  end

  // State, pc and instruction registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= FETCH_OP;
      pc_r    <= RESET_VEC;
      raw_r   <= 24'h000000;
      len_r   <= LEN_1B;
      run_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      pc_r    <= pc_n;
      raw_r   <= raw_n;
      len_r   <= len_n;
      run_r   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed self-checking bench for fetch with a wait-state programmable memory model.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        pc_load;
  logic [15:0] pc_target;
  logic [23:0] raw;
  logic [1:0]  len;
  logic        ir_we;
  logic [15:0] pc;
  logic        fault;

  logic [7:0]  pmem [0:65535];
  int          wait_n = 0;
  int          wcnt = 0;
  int          chk_cnt = 0;
  int          pass_cnt = 0;

  fetch_if bus();

  always #5 clk = ~clk;

  // Memory acks after wait_n stalled cycles at the same request
  assign bus.mem_ack   = bus.mem_req && (wcnt >= wait_n);
  assign bus.mem_rdata = pmem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_req && !bus.mem_ack && !pc_load) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  fetch #(.RESET_VEC(16'h0100)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem       (bus),
    .hold      (hold),
    .pc_load   (pc_load),
    .pc_target (pc_target),
    .raw       (raw),
    .len       (len),
    .ir_we     (ir_we),
    .pc        (pc),
    .fault     (fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Drive this cycle's inputs mid-cycle, then let outputs settle for sampling
  task automatic step(input logic h, input logic pl, input logic [15:0] tgt);
    @(negedge clk);
    hold      = h;
    pc_load   = pl;
    pc_target = tgt;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) pmem[i] = 8'h00;
    pmem[16'h0100] = 8'h05;
    pmem[16'h0200] = 8'h8A; pmem[16'h0201] = 8'h12; pmem[16'h0202] = 8'h34;
    pmem[16'h0300] = 8'h3F;
    pmem[16'h0400] = 8'h4C; pmem[16'h0401] = 8'h99;
    pmem[16'h0600] = 8'hC0;
    pmem[16'h0700] = 8'h05;
    pmem[16'hFFFF] = 8'h40; pmem[16'h0000] = 8'h77;

    rst = 1'b0; hold = 1'b0; pc_load = 1'b0; pc_target = 16'h0000;
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    chk("rst_pc", pc, 16'h0100);
    chk("rst_req", bus.mem_req, 1'b0);
    chk("rst_irwe", ir_we, 1'b0);
    chk("rst_raw", raw, 24'h000000);
    chk("rst_len", len, 2'd0);
    chk("rst_fault", fault, 1'b0);

    // Reset release: request appears the cycle after, 1-byte op issues at cycle 1
    @(negedge clk); rst = 1'b1; #1;
    chk("rel_req", bus.mem_req, 1'b0);
    step(1'b0, 1'b0, 16'h0000);
    chk("t1_req", bus.mem_req, 1'b1);
    chk("t1_addr", bus.mem_addr, 16'h0100);
    step(1'b0, 1'b0, 16'h0000);
    chk("t1_irwe", ir_we, 1'b1);
    chk("t1_raw", raw, 24'h050000);
    chk("t1_len", len, 2'd0);
    chk("t1_pc", pc, 16'h0101);
    step(1'b0, 1'b0, 16'h0000);
    chk("t1_b2b_req", bus.mem_req, 1'b1);
    chk("t1_b2b_addr", bus.mem_addr, 16'h0101);
    chk("t1_b2b_irwe", ir_we, 1'b0);

    // 3-byte instruction with two wait cycles per byte
    wait_n = 2;
    step(1'b0, 1'b1, 16'h0200);
    for (int c = 0; c < 9; c++) begin
      step(1'b0, 1'b0, 16'h0000);
      chk("t2_addr", bus.mem_addr, 32'(16'h0200 + c / 3));
      chk("t2_req", bus.mem_req, 1'b1);
      chk("t2_irwe", ir_we, 1'b0);
    end
    step(1'b0, 1'b0, 16'h0000);
    chk("t2_irwe_on", ir_we, 1'b1);
    chk("t2_raw", raw, 24'h8A1234);
    chk("t2_len", len, 2'd2);
    chk("t2_pc", pc, 16'h0203);
    step(1'b0, 1'b0, 16'h0000);
    chk("t2_irwe_off", ir_we, 1'b0);
    chk("t2_next_addr", bus.mem_addr, 16'h0203);
    wait_n = 0;

    // Hold for four cycles in ISSUE
    step(1'b0, 1'b1, 16'h0300);
    step(1'b1, 1'b0, 16'h0000);
    chk("t3_addr", bus.mem_addr, 16'h0300);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 16'h0000);
      chk("t3_hold_irwe", ir_we, 1'b0);
      chk("t3_hold_raw", raw, 24'h3F0000);
      chk("t3_hold_req", bus.mem_req, 1'b0);
    end
    step(1'b0, 1'b0, 16'h0000);
    chk("t3_irwe", ir_we, 1'b1);
    chk("t3_raw", raw, 24'h3F0000);
    step(1'b0, 1'b0, 16'h0000);
    chk("t3_next_req", bus.mem_req, 1'b1);
    chk("t3_next_addr", bus.mem_addr, 16'h0301);

    // Redirect during FETCH_D1 with a same-cycle ack, then during ISSUE
    step(1'b0, 1'b1, 16'h0400);
    step(1'b0, 1'b0, 16'h0000);
    chk("t4_op_addr", bus.mem_addr, 16'h0400);
    step(1'b0, 1'b1, 16'h2000);
    chk("t4_d1_addr", bus.mem_addr, 16'h0401);
    chk("t4_d1_irwe", ir_we, 1'b0);
    step(1'b0, 1'b0, 16'h0000);
    chk("t4_pc", pc, 16'h2000);
    chk("t4_addr", bus.mem_addr, 16'h2000);
    chk("t4_irwe", ir_we, 1'b0);
    step(1'b0, 1'b1, 16'h0500);
    chk("t4_iss_irwe", ir_we, 1'b0);
    chk("t4_iss_raw", raw, 24'h000000);
    chk("t4_iss_pc", pc, 16'h2001);
    step(1'b0, 1'b0, 16'h0000);
    chk("t4_redir_pc", pc, 16'h0500);
    chk("t4_redir_req", bus.mem_req, 1'b1);

    // pc wrap across 16'hFFFF
    step(1'b0, 1'b1, 16'hFFFF);
    step(1'b0, 1'b0, 16'h0000);
    chk("t5_addr0", bus.mem_addr, 16'hFFFF);
    step(1'b0, 1'b0, 16'h0000);
    chk("t5_addr1", bus.mem_addr, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    chk("t5_irwe", ir_we, 1'b1);
    chk("t5_raw", raw, 24'h407700);
    chk("t5_len", len, 2'd1);
    chk("t5_pc", pc, 16'h0001);

    // Illegal opcode
    step(1'b0, 1'b1, 16'h0600);
    step(1'b0, 1'b0, 16'h0000);
    chk("t6_addr", bus.mem_addr, 16'h0600);
`ifdef FETCH_ILLEGAL_TRAP_EN
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 16'h0000);
      chk("t6_fault", fault, 1'b1);
      chk("t6_req", bus.mem_req, 1'b0);
      chk("t6_irwe", ir_we, 1'b0);
      chk("t6_pc", pc, 16'h0601);
    end
    step(1'b0, 1'b1, 16'h0700);
    step(1'b0, 1'b0, 16'h0000);
    chk("t6_exit_fault", fault, 1'b0);
    chk("t6_exit_addr", bus.mem_addr, 16'h0700);
    step(1'b0, 1'b0, 16'h0000);
    chk("t6_exit_irwe", ir_we, 1'b1);
    chk("t6_exit_raw", raw, 24'h050000);
`else
    step(1'b0, 1'b0, 16'h0000);
    chk("t6_irwe", ir_we, 1'b1);
    chk("t6_raw", raw, 24'hC00000);
    chk("t6_len", len, 2'd0);
    chk("t6_fault", fault, 1'b0);
    step(1'b0, 1'b0, 16'h0000);
    chk("t6_next_addr", bus.mem_addr, 16'h0601);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
